// File: rtl/seg_display_scanner_pkg.sv
// Shared definitions for the 4-digit 7-segment scanner: character codes,
// scan FSM state encoding and active-low segment patterns.
package seg_display_scanner_pkg;

  // Character codes above the hex range
  localparam logic [4:0] CH_BLANK = 5'h10;
  localparam logic [4:0] CH_DASH  = 5'h11;

  // Scan FSM: DEAD = all anodes off between digits, ON = one digit lit
  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-low (0 = segment lit)
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Active-low anode pattern for a digit index (an[3] = leftmost)
  function automatic logic [3:0] anode_for(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/seg_display_scanner_char_to_seg.sv
// Combinational character decoder: 5-bit code -> active-low {g..a} pattern.
// Hex 0-F, 0x11 dash, everything else blank.
module char_to_seg
  import seg_display_scanner_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  // Table lookup; unused codes fall through to blank
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'h00: seg = SEG_0;
      5'h01: seg = SEG_1;
      5'h02: seg = SEG_2;
      5'h03: seg = SEG_3;
      5'h04: seg = SEG_4;
      5'h05: seg = SEG_5;
      5'h06: seg = SEG_6;
      5'h07: seg = SEG_7;
      5'h08: seg = SEG_8;
      5'h09: seg = SEG_9;
      5'h0A: seg = SEG_A;
      5'h0B: seg = SEG_B;
      5'h0C: seg = SEG_C;
      5'h0D: seg = SEG_D;
      5'h0E: seg = SEG_E;
      5'h0F: seg = SEG_F;
      CH_DASH: seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_scanner.sv
// 4-digit common-anode display scanner with a 16-entry character memory.
// Each digit: DEAD blanking phase (sample + decode on its last cycle),
// then ON phase with the registered pattern held constant.
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int REFRESH_CYCLES  = 12500,
  parameter int DEADTIME_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] adr3,
  input  logic [3:0] adr2,
  input  logic [3:0] adr1,
  input  logic [3:0] adr0,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  // Phase counter sized for the longer of the two phases
  localparam int MAXP = (REFRESH_CYCLES > DEADTIME_CYCLES) ? REFRESH_CYCLES : DEADTIME_CYCLES;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam logic [CW-1:0] R_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DEADTIME_CYCLES - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      digit, digit_nxt;
  logic [3:0]      an_nxt;
  logic [6:0]      seg_nxt;
  logic            fd_nxt;

  logic [4:0]      mem [16];
  logic [3:0]      rd_addr;
  logic [4:0]      rd_code;
  logic [6:0]      dec_seg;

  // Character memory; cleared to blank on reset, written from the UART path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= CH_BLANK;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Select the address of the digit being prepared; only consumed on the
  // sampling cycle, so address changes elsewhere never reach the display
  always_comb begin
    rd_addr = adr0;
    case (digit)
      2'd3: rd_addr = adr3;
      2'd2: rd_addr = adr2;
      2'd1: rd_addr = adr1;
      2'd0: rd_addr = adr0;
      default: rd_addr = adr0;
    endcase
  end

  // Old contents are read here; a same-edge write lands after the sample
  assign rd_code = mem[rd_addr];

  char_to_seg u_char_to_seg (
    .code (rd_code),
    .seg  (dec_seg)
  );

  // Next-state and next-output logic for the DEAD/ON scan
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    digit_nxt = digit;
    an_nxt    = an;
    seg_nxt   = seg;
    fd_nxt    = 1'b0;
    case (state)
      ST_DEAD: begin
        if (cnt == D_LAST) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
          an_nxt    = anode_for(digit);
          seg_nxt   = dec_seg;
        end
      end
      ST_ON: begin
        if (cnt == R_LAST) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = '0;
          an_nxt    = 4'b1111;
          digit_nxt = digit - 2'd1;
          fd_nxt    = (digit == 2'd0);
        end
      end
      default: begin
        state_nxt = ST_DEAD;
        cnt_nxt   = '0;
        an_nxt    = 4'b1111;
      end
    endcase
  end

  // State and registered outputs; reset blanks the display immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_DEAD;
      cnt        <= '0;
      digit      <= 2'd3;
      an         <= 4'b1111;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit      <= digit_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (REFRESH=4, DEAD=2).
// The reference model derives the expected display from the elapsed cycle
// count since reset release plus a shadow copy of the character memory.
module tb_seg_display_scanner;

  localparam int R = 4;
  localparam int D = 2;
  localparam int P = R + D;
  localparam int FRAME = 4 * P;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] adr3, adr2, adr1, adr0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_data;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  int         n;          // clock edges since reset release
  logic [4:0] mmem [16];
  logic [6:0] mseg;

  localparam logic [6:0] TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg_display_scanner #(.REFRESH_CYCLES(R), .DEADTIME_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .adr3(adr3), .adr2(adr2), .adr1(adr1), .adr0(adr0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .an(an), .seg(seg), .frame_done(frame_done));

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [4:0] c);
    logic [3:0] lo;
    lo = c[3:0];
    if (c < 5'd16) return TAB[lo];
    if (c == 5'h11) return 7'b0111111;
    return 7'b1111111;
  endfunction

  // Digit lit (or about to be lit) in the slot containing edge k
  function automatic int ref_digit(input int k);
    return 3 - ((k / P) % 4);
  endfunction

  function automatic logic [3:0] ref_an(input int k);
    if ((k % P) < D) return 4'b1111;
    case (ref_digit(k))
      3: return 4'b0111;
      2: return 4'b1011;
      1: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  function automatic logic ref_fd(input int k);
    return (k > 0) && (k % FRAME == 0);
  endfunction

  function automatic logic [3:0] adr_of(input int d);
    case (d)
      3: return adr3;
      2: return adr2;
      1: return adr1;
      default: return adr0;
    endcase
  endfunction

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 16; i++) mmem[i] = 5'h10;
    mseg = 7'b1111111;
  endtask

  // One clock: update model with pre-edge inputs, then advance and settle
  task automatic tick();
    if (((n + 1) % P) == D) mseg = ref_seg(mmem[adr_of(ref_digit(n + 1))]);
    if (wr_en) mmem[wr_addr] = wr_data;
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({an, seg, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
      fails++;
      $display("FAIL reset_hold: got an=%b seg=%b fd=%b, want 1111/1111111/0", an, seg, frame_done);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    // Two dead cycles, then digit 3 blank, then the rest of the blank scan
    for (int i = 0; i < FRAME + 4; i++) begin
      checks++;
      if ({an, seg, frame_done} !== {ref_an(n), mseg, ref_fd(n)} || seg !== 7'b1111111) begin
        fails++;
        $display("FAIL blank_scan n=%0d: got an=%b seg=%b fd=%b, want an=%b seg=1111111 fd=%b",
                 n, an, seg, frame_done, ref_an(n), ref_fd(n));
      end
      if (n == D) begin
        checks++;
        if (an !== 4'b0111) begin
          fails++;
          $display("FAIL first_lit: got an=%b, want 0111", an);
        end
      end
      tick();
    end
  endtask

  task automatic test_digits();
    int guard;
    do_write(4'd0, 5'h01);
    do_write(4'd5, 5'h08);
    adr3 = 4'd0; adr2 = 4'd5; adr1 = 4'd0; adr0 = 4'd5;
    guard = 0;
    while ((n % FRAME) != 0 && guard < 100) begin tick(); guard++; end
    checks++;
    if (guard >= 100) begin fails++; $display("FAIL digits_align: no frame boundary"); end
    for (int i = 0; i < FRAME; i++) begin
      logic [6:0] want;
      want = (an == 4'b0111 || an == 4'b1101) ? 7'b1111001 : 7'b0000000;
      checks++;
      if ({an, seg, frame_done} !== {ref_an(n), mseg, ref_fd(n)} ||
          (an != 4'b1111 && seg !== want)) begin
        fails++;
        $display("FAIL digits n=%0d: got an=%b seg=%b fd=%b, want an=%b seg=%b fd=%b",
                 n, an, seg, frame_done, ref_an(n), mseg, ref_fd(n));
      end
      tick();
    end
  endtask

  task automatic test_timing();
    int pulses, last_pulse, gap, lit3, guard;
    pulses = 0; last_pulse = -1; gap = 0; lit3 = 0; guard = 0;
    while ((n % FRAME) != 0 && guard < 100) begin tick(); guard++; end
    checks++;
    if (guard >= 100) begin fails++; $display("FAIL timing_align: no frame boundary"); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if (an !== ref_an(n) || frame_done !== ref_fd(n)) begin
        fails++;
        $display("FAIL timing n=%0d: got an=%b fd=%b, want an=%b fd=%b",
                 n, an, frame_done, ref_an(n), ref_fd(n));
      end
      if (frame_done) begin
        if (last_pulse >= 0) gap = i - last_pulse;
        last_pulse = i;
        pulses++;
      end
      if (an == 4'b0111) lit3++;
    end
    checks++;
    if (pulses != 2 || gap != 24 || lit3 != 8) begin
      fails++;
      $display("FAIL frame_period: got pulses=%0d gap=%0d lit3=%0d, want 2/24/8", pulses, gap, lit3);
    end
  endtask

  task automatic test_no_tearing();
    int guard;
    guard = 0;
    while (!((n % P) == D && ref_digit(n) == 3) && guard < 100) begin tick(); guard++; end
    checks++;
    if (guard >= 100) begin fails++; $display("FAIL tear_align: digit3 never lit"); end
    // Digit 3 lit with mem[0]=0x01: rewrite it and move adr3 mid-phase
    adr3 = 4'd3;
    do_write(4'd0, 5'h0E);
    for (int i = 0; i < R - 1; i++) begin
      checks++;
      if (an !== 4'b0111 || seg !== 7'b1111001 || seg !== mseg) begin
        fails++;
        $display("FAIL no_tearing n=%0d: got an=%b seg=%b, want 0111/1111001", n, an, seg);
      end
      if (i == 0) adr3 = 4'd0;
      tick();
    end
    guard = 0;
    while (!((n % P) == D && ref_digit(n) == 3) && guard < 100) begin tick(); guard++; end
    checks++;
    if (an !== 4'b0111 || seg !== 7'b0000110 || seg !== mseg) begin
      fails++;
      $display("FAIL next_visit: got an=%b seg=%b, want 0111/0000110", an, seg);
    end
  endtask

  task automatic test_sample_write();
    int guard;
    logic [6:0] old;
    guard = 0;
    while (!(((n + 1) % P) == D && ref_digit(n + 1) == 2) && guard < 100) begin tick(); guard++; end
    checks++;
    if (guard >= 100) begin fails++; $display("FAIL sample_align: digit2 sample not found"); end
    old = ref_seg(mmem[adr2]);
    do_write(adr2, 5'h11);
    checks++;
    if (an !== 4'b1011 || seg !== old || seg !== mseg) begin
      fails++;
      $display("FAIL sample_write_old: got an=%b seg=%b, want 1011/%b", an, seg, old);
    end
    repeat (FRAME) tick();
    checks++;
    if (an !== 4'b1011 || seg !== 7'b0111111 || seg !== mseg) begin
      fails++;
      $display("FAIL sample_write_new: got an=%b seg=%b, want 1011/0111111", an, seg);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      checks++;
      if ({an, seg, frame_done} !== {ref_an(n), mseg, ref_fd(n)}) begin
        fails++;
        $display("FAIL random n=%0d: got an=%b seg=%b fd=%b, want an=%b seg=%b fd=%b",
                 n, an, seg, frame_done, ref_an(n), mseg, ref_fd(n));
      end
      wr_en   = ($urandom_range(3) == 0);
      wr_addr = 4'($urandom_range(15));
      wr_data = 5'($urandom_range(31));
      if ($urandom_range(9) == 0) begin
        case ($urandom_range(3))
          0: adr0 = 4'($urandom_range(15));
          1: adr1 = 4'($urandom_range(15));
          2: adr2 = 4'($urandom_range(15));
          default: adr3 = 4'($urandom_range(15));
        endcase
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (!((n % P) == D + 1 && mseg != 7'b1111111) && guard < 200) begin tick(); guard++; end
    checks++;
    if (guard >= 200) begin fails++; $display("FAIL areset_align: no lit non-blank digit"); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({an, seg, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got an=%b seg=%b fd=%b, want 1111/1111111/0", an, seg, frame_done);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < FRAME + 2; i++) begin
      checks++;
      if ({an, seg, frame_done} !== {ref_an(n), mseg, ref_fd(n)} || seg !== 7'b1111111) begin
        fails++;
        $display("FAIL post_reset n=%0d: got an=%b seg=%b fd=%b, want an=%b seg=1111111 fd=%b",
                 n, an, seg, frame_done, ref_an(n), ref_fd(n));
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    adr3 = '0; adr2 = '0; adr1 = '0; adr0 = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    test_reset();
    test_digits();
    test_timing();
    test_no_tearing();
    test_sample_write();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
